shift_exec_seq: RTL and testbench
=================================

Name: shift_exec_seq

Overview:
Multi-cycle shift execution unit that sits directly downstream of instruction decode and feeds the write-back stage. It is the sequential counterpart of the combinational sll_32 shifter. It accepts a decoded shift operation (sll/srl/sra and the variable forms sllv/srlv/srav), shifts the operand one bit per clock, and presents the result to write-back under a valid/ready handshake.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
flush  input  1  synchronous abort; returns the unit to IDLE
in_valid  input  1  decode presents an operation
in_ready  output  1  unit can accept an operation (high only in IDLE)
op  input  2  00 = SLL, 10 = SRL, 11 = SRA; 01 is decoded as SLL
var_sel  input  1  1 = amount from rs[SHW-1:0] (xxxv forms); 0 = amount from shamt
rt  input  WIDTH  operand to shift
rs  input  WIDTH  variable shift amount source; bits above SHW-1 are ignored
shamt  input  SHW  immediate shift amount
out_valid  output  1  result available
out_ready  input  1  write-back accepts the result
rd  output  WIDTH  shift result
busy  output  1  high whenever the state is not IDLE

Behaviour:
- Reset (rst_n low at a clock edge): state = IDLE, in_ready = 1, out_valid = 0, busy = 0, rd = 0, internal count = 0. Reset has priority over flush and handshakes and aborts any operation in progress.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid at an edge: latch data = rt, op, and cnt = (var_sel ? rs[4:0] : shamt).
  - If cnt == 0, go to DONE; otherwise go to SHIFT.
- SHIFT:
  - Each edge performs a one-bit shift of data and decrements cnt.
  - SLL: data = {data[30:0], 0}. SRL: data = {0, data[31:1]}. SRA: data = {data[31], data[31:1]}.
  - When cnt reaches 0 (after the edge where cnt == 1), go to DONE.
  - in_valid is ignored; in_ready = 0.
- DONE:
  - out_valid = 1 and rd = data.
  - On an edge with out_ready = 1, go to IDLE. out_valid drops, and rd keeps its last value until the next completion.
  - out_valid, once high, stays high and rd stays stable until the handshake completes.
- Latency: let the accept cycle be the cycle in which in_valid and in_ready are both high. out_valid is first high amount+1 cycles after the accept cycle (amount 0 gives 1 cycle; amount 31 gives 32 cycles).
- Throughput: one operation per (amount + 2) cycles when out_ready is held high. There is no overlap; a new accept can happen only in IDLE, i.e. in the cycle after the output handshake.
- flush = 1 at an edge: go to IDLE from any state, out_valid = 0, and any pending result is discarded. If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Amount wrap: only the low 5 bits are used, so rs = 0x24 shifts by 4 and rs = 0x20 shifts by 0.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges while in_valid = 1 -> in_ready = 1, out_valid = 0, busy = 0, rd = 00000000, and nothing is accepted.
- Immediate forms with rt = 805C9BD2, shamt = 4, out_ready = 1 -> SLL gives 05C9BD20, SRL gives 0805C9BD, SRA gives F805C9BD; each has out_valid high exactly 5 cycles after the accept cycle.
- Boundaries with rt = 805C9BD2 -> shamt 0, SLL gives 805C9BD2 (out_valid 1 cycle after accept); shamt 31 gives SLL 00000000, SRL 00000001, SRA FFFFFFFF (32 cycles).
- Variable form: var_sel = 1, rs = 00000024, shamt = 7, op = SLL -> rd = 05C9BD20 (shift by 4, shamt ignored).
- Backpressure: out_ready = 0 for 10 cycles after DONE -> out_valid and rd = 05C9BD20 stay stable and in_ready = 0; a new in_valid pulse is not accepted until the cycle after out_ready rises.
- Abort: flush after 3 shift cycles of an SLL by 20 -> IDLE next cycle, out_valid never rises, and the next SLL by 1 of 00000001 returns 00000002. Repeat the same abort with rst_n instead of flush -> rd = 00000000.

Source files
------------

// File: rtl/shift_exec_seq.sv
// Bit-serial shift execution unit: one bit of shift per clock between decode
// and write-back, with a valid/ready handshake on both sides.
module shift_exec_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             var_sel,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] rs,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data, data_sh;
  logic [1:0]       opr;
  logic [SHW-1:0]   cnt, amt;
  logic             unused_rs;

  // Only the low SHW bits of rs form the amount; the rest wrap away.
  assign amt       = var_sel ? rs[SHW-1:0] : shamt;
  assign unused_rs = ^rs[WIDTH-1:SHW];

  always_comb begin
    data_sh = {data[WIDTH-2:0], 1'b0};
    if (opr == 2'b10)      data_sh = {1'b0, data[WIDTH-1:1]};
    else if (opr == 2'b11) data_sh = {data[WIDTH-1], data[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nx = (amt == '0) ? DONE : SHIFT;
        SHIFT:   if (cnt == SHW'(1)) state_nx = DONE;
        DONE:    if (out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // rd is loaded only on entry to DONE, so it holds the last completed result
  // across IDLE and flushed operations.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= '0;
      opr   <= 2'b00;
      cnt   <= '0;
      rd    <= '0;
    end else begin
      state <= state_nx;
      if (!flush) begin
        case (state)
          IDLE: if (in_valid) begin
            data <= rt;
            opr  <= op;
            cnt  <= amt;
            if (amt == '0) rd <= rt;
          end
          SHIFT: begin
            data <= data_sh;
            cnt  <= cnt - SHW'(1);
            if (cnt == SHW'(1)) rd <= data_sh;
          end
          default: ;
        endcase
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_shift_exec_seq.sv
// Scoreboard bench for shift_exec_seq: expected result and latency are queued
// at issue time from a reference shift model and compared on completion.
module tb_shift_exec_seq;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, var_sel, out_valid, out_ready, busy;
  logic [1:0]  op;
  logic [31:0] rt, rs, rd;
  logic [4:0]  shamt;

  typedef struct {logic [31:0] d; int lat;} exp_t;
  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  shift_exec_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .var_sel(var_sel), .rt(rt), .rs(rs), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .rd(rd), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(logic [1:0] o, logic [31:0] v, logic [4:0] a);
    if (o == 2'b10) return v >> a;
    if (o == 2'b11) return $unsigned($signed(v) >>> a);
    return v << a;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive one operation from IDLE and queue its expectation; no checking here.
  task automatic send(input logic [1:0] o, input logic vs, input logic [31:0] t,
                      input logic [31:0] s, input logic [4:0] sh);
    exp_t e;
    logic [4:0] a;
    int n = 0;
    while (!in_ready && n < 64) begin tick(); n++; end
    op = o; var_sel = vs; rt = t; rs = s; shamt = sh; in_valid = 1'b1;
    a = vs ? s[4:0] : sh;
    e.d = model(o, t, a);
    e.lat = int'(a) + 1;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Cycles counted from the accept cycle until out_valid is seen (bounded).
  task automatic wait_out(output logic [31:0] r, output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 64) begin tick(); cyc++; end
    r = rd;
  endtask

  task automatic xfer(input logic [1:0] o, input logic vs, input logic [31:0] t,
                      input logic [31:0] s, input logic [4:0] sh,
                      output logic [31:0] r, output int cyc, output exp_t e);
    send(o, vs, t, s, sh);
    wait_out(r, cyc);
    e = q.pop_front();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; op = 2'b00; var_sel = 1'b0;
    rt = 32'hFFFF_FFFF; rs = '0; shamt = 5'd3; out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept busy=%b exp=0", busy); end
  endtask

  task automatic test_imm();
    logic [1:0] ops [3] = '{2'b00, 2'b10, 2'b11};
    logic [31:0] r; int c; exp_t e;
    foreach (ops[i]) begin
      xfer(ops[i], 1'b0, 32'h805C9BD2, 32'h0, 5'd4, r, c, e);
      checks++; if (r !== e.d) begin errors++; $display("FAIL imm_rd op=%b got=%h exp=%h", ops[i], r, e.d); end
      checks++; if (c !== e.lat) begin errors++; $display("FAIL imm_lat op=%b got=%0d exp=%0d", ops[i], c, e.lat); end
    end
  endtask

  task automatic test_bounds();
    logic [1:0] ops [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
    logic [4:0] amts [4] = '{5'd0, 5'd31, 5'd31, 5'd31};
    logic [31:0] r; int c; exp_t e;
    foreach (ops[i]) begin
      xfer(ops[i], 1'b0, 32'h805C9BD2, 32'h0, amts[i], r, c, e);
      checks++; if (r !== e.d) begin errors++; $display("FAIL bound_rd op=%b amt=%0d got=%h exp=%h", ops[i], amts[i], r, e.d); end
      checks++; if (c !== e.lat) begin errors++; $display("FAIL bound_lat op=%b amt=%0d got=%0d exp=%0d", ops[i], amts[i], c, e.lat); end
    end
  endtask

  task automatic test_var();
    logic [31:0] r; int c; exp_t e;
    xfer(2'b00, 1'b1, 32'h805C9BD2, 32'h0000_0024, 5'd7, r, c, e);
    checks++; if (r !== 32'h05C9BD20) begin errors++; $display("FAIL var_rd got=%h exp=05c9bd20", r); end
    checks++; if (c !== 5) begin errors++; $display("FAIL var_lat got=%0d exp=5", c); end
    xfer(2'b11, 1'b1, 32'h805C9BD2, 32'hFFFF_FFE0, 5'd9, r, c, e);
    checks++; if (r !== e.d || c !== 1) begin errors++; $display("FAIL var_wrap0 got=%h/%0d exp=%h/1", r, c, e.d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] r; int c; exp_t e; int bad = 0;
    out_ready = 1'b0;
    send(2'b00, 1'b0, 32'h805C9BD2, 32'h0, 5'd4);
    wait_out(r, c);
    e = q.pop_front();
    checks++; if (r !== 32'h05C9BD20 || c !== 5) begin errors++; $display("FAIL bp_first got=%h/%0d exp=05c9bd20/5", r, c); end
    op = 2'b10; var_sel = 1'b0; rt = 32'h8000_0000; shamt = 5'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || rd !== 32'h05C9BD20 || in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold bad_cycles=%0d exp=0", bad); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release ov=%b ir=%b exp=0/1", out_valid, in_ready); end
    e.d = model(2'b10, 32'h8000_0000, 5'd1); e.lat = 2;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    wait_out(r, c);
    e = q.pop_front();
    tick();
    checks++; if (r !== e.d || c !== e.lat) begin errors++; $display("FAIL bp_next got=%h/%0d exp=%h/%0d", r, c, e.d, e.lat); end
  endtask

  task automatic start_sll20();
    op = 2'b00; var_sel = 1'b0; rt = 32'h0000_0F0F; shamt = 5'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_flush();
    logic [31:0] r, prev; int c; exp_t e; int seen = 0;
    prev = rd;
    start_sll20();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL flush_idle ir=%b busy=%b exp=1/0", in_ready, busy); end
    for (int i = 0; i < 24; i++) begin tick(); if (out_valid) seen++; end
    checks++; if (seen != 0 || rd !== prev) begin errors++; $display("FAIL flush_discard ov_cycles=%0d rd=%h exp=0/%h", seen, rd, prev); end
    op = 2'b00; rt = 32'h1; shamt = 5'd2; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_wins busy=%b exp=0", busy); end
    xfer(2'b00, 1'b0, 32'h1, 32'h0, 5'd1, r, c, e);
    checks++; if (r !== 32'h2 || c !== 2) begin errors++; $display("FAIL flush_next got=%h/%0d exp=00000002/2", r, c); end
  endtask

  task automatic test_rst_abort();
    logic [31:0] r; int c; exp_t e;
    start_sll20();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (rd !== 32'h0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort rd=%h ir=%b ov=%b exp=00000000/1/0", rd, in_ready, out_valid); end
    xfer(2'b00, 1'b0, 32'h1, 32'h0, 5'd1, r, c, e);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL rst_abort_next got=%h exp=00000002", r); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int c; exp_t e;
    logic [1:0] o; logic vs; logic [31:0] t, s; logic [4:0] sh;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3)); vs = 1'($urandom_range(0, 1));
      t = $urandom; s = $urandom; sh = 5'($urandom_range(0, 31));
      xfer(o, vs, t, s, sh, r, c, e);
      checks++; if (r !== e.d || c !== e.lat) begin errors++; $display("FAIL b2b_%0d op=%b rt=%h got=%h/%0d exp=%h/%0d", i, o, t, r, c, e.d, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_imm();
    test_bounds();
    test_var();
    test_backpressure();
    test_flush();
    test_rst_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
